// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_ctrl
//  Purpose  : Volleyball rally/scoring controller. Watches the ball position,
//             detects floor contact, awards points by court side, sequences
//             IDLE -> SERVE -> PLAY -> OVER and holds both scores.
//  Revision : 1.0  initial release
// ============================================================================
module game_ctrl #(
  parameter int BALL_W       = 30,
  parameter int BALL_H       = 30,
  parameter int GROUND_Y     = 220,
  parameter int NET_X        = 160,
  parameter int NET_W        = 6,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  Player_score,
  output logic [3:0]  NPC_score,
  output logic        point
);

  // Counter only has to reach SERVE_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_CYCLES - 1);
  localparam logic [3:0]       WIN_VAL  = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             start_btn_q;
  logic [3:0]       player_q, player_d;
  logic [3:0]       npc_q, npc_d;
  logic             who_q, who_d;
  logic             point_q, point_d;

  logic             start_rise;
  logic             landed;
  logic             left_side;
  logic             score_evt;
  logic [3:0]       player_inc;
  logic [3:0]       npc_inc;

  // Geometry is evaluated in 13 bits so a ball near the 12-bit limit cannot wrap.
  assign start_rise = start_btn & ~start_btn_q;
  assign landed     = ({1'b0, Ball_Y} + 13'(BALL_H)) >= 13'(GROUND_Y);
  assign left_side  = ({1'b0, Ball_X} + 13'(BALL_W / 2)) < 13'(NET_X + NET_W / 2);
  assign score_evt  = (state_q == ST_PLAY) && armed_q && landed;
  assign player_inc = (player_q == 4'hF) ? player_q : player_q + 4'd1;
  assign npc_inc    = (npc_q == 4'hF) ? npc_q : npc_q + 4'd1;

  // Next-state logic: sequencing, serve delay, scoring and arming.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    player_d = player_q;
    npc_d    = npc_q;
    who_d    = who_q;
    point_d  = 1'b0;
    // The ball must be seen airborne in PLAY before a landing can count, so a
    // ball still resting on the floor at PLAY entry never scores.
    armed_d  = (state_q == ST_PLAY) && !score_evt && (armed_q || !landed);

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d  = ST_SERVE;
          player_d = 4'd0;
          npc_d    = 4'd0;
          who_d    = 1'b0;
          cnt_d    = '0;
        end
      end
      ST_SERVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PLAY: begin
        if (score_evt) begin
          point_d = 1'b1;
          cnt_d   = '0;
          if (left_side) begin
            player_d = player_inc;
            who_d    = 1'b0;
            state_d  = (player_inc == WIN_VAL) ? ST_OVER : ST_SERVE;
          end else begin
            npc_d   = npc_inc;
            who_d   = 1'b1;
            state_d = (npc_inc == WIN_VAL) ? ST_OVER : ST_SERVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      start_btn_q <= 1'b0;
      player_q    <= 4'd0;
      npc_q       <= 4'd0;
      who_q       <= 1'b0;
      point_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      start_btn_q <= start_btn;
      player_q    <= player_d;
      npc_q       <= npc_d;
      who_q       <= who_d;
      point_q     <= point_d;
    end
  end

  assign Game_state   = state_q;
  assign who_win      = who_q;
  assign Player_score = player_q;
  assign NPC_score    = npc_q;
  assign point        = point_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_ctrl
//  Purpose  : Self-checking bench for game_ctrl: directed vector table,
//             game-end sequence and randomized play against a rule model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_game_ctrl;

  localparam int BW = 30, BH = 30, GY = 220, NX = 160, NW = 6;
  localparam int WS = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_btn = 1'b0;
  logic [11:0] Ball_X = 12'd0;
  logic [11:0] Ball_Y = 12'd0;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  Player_score;
  logic [3:0]  NPC_score;
  logic        point;

  game_ctrl #(
    .BALL_W(BW), .BALL_H(BH), .GROUND_Y(GY), .NET_X(NX), .NET_W(NW),
    .WIN_SCORE(WS), .SERVE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn),
    .Ball_X(Ball_X), .Ball_Y(Ball_Y),
    .Game_state(Game_state), .who_win(who_win),
    .Player_score(Player_score), .NPC_score(NPC_score), .point(point)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- rule model ----------------
  int m_state, m_p, m_n, m_who, m_point, m_cnt, m_armed, m_prev;

  function automatic void model_reset();
    m_state = 0; m_p = 0; m_n = 0; m_who = 0; m_point = 0;
    m_cnt = 0; m_armed = 0; m_prev = 0;
  endfunction

  function automatic void model_clear_game();
    m_state = 1; m_p = 0; m_n = 0; m_who = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input int s, input int x, input int y);
    bit rise, landed, left;
    int was;
    rise   = (s != 0) && (m_prev == 0);
    m_prev = s;
    landed = (y + BH) >= GY;
    left   = (x + BW / 2) < (NX + NW / 2);
    was    = m_state;
    m_point = 0;
    if (was == 0 || was == 3) begin
      if (rise) model_clear_game();
    end else if (was == 1) begin
      if (m_cnt == SC - 1) begin m_state = 2; m_cnt = 0; end
      else m_cnt++;
    end else begin
      if (m_armed != 0 && landed) begin
        m_point = 1;
        m_cnt = 0;
        m_armed = 0;
        if (left) begin
          m_p = (m_p < 15) ? m_p + 1 : 15; m_who = 0;
          m_state = (m_p == WS) ? 3 : 1;
        end else begin
          m_n = (m_n < 15) ? m_n + 1 : 15; m_who = 1;
          m_state = (m_n == WS) ? 3 : 1;
        end
      end else if (!landed) begin
        m_armed = 1;
      end
    end
    if (was != 2) m_armed = 0;
  endfunction

  // Apply one cycle of inputs, clock it, compare against the model.
  task automatic step(input int s, input int x, input int y);
    start_btn = s[0];
    Ball_X    = x[11:0];
    Ball_Y    = y[11:0];
    @(posedge clk);
    model_edge(s, x, y);
    #1;
    chk("model state", int'(Game_state), m_state);
    chk("model player", int'(Player_score), m_p);
    chk("model npc", int'(NPC_score), m_n);
    chk("model who_win", int'(who_win), m_who);
    chk("model point", int'(point), m_point);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, " rst state"}, int'(Game_state), 0);
    chk({tag, " rst player"}, int'(Player_score), 0);
    chk({tag, " rst npc"}, int'(NPC_score), 0);
    chk({tag, " rst who"}, int'(who_win), 0);
    chk({tag, " rst point"}, int'(point), 0);
    model_reset();
    #2;
    reset_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int s; int x; int y;
    int st; int p; int n; int w; int pt;
  } vec_t;

  vec_t tbl[$];

  function automatic void addv(input int s, input int x, input int y,
                               input int st, input int p, input int n,
                               input int w, input int pt);
    vec_t v;
    v.s = s; v.x = x; v.y = y; v.st = st; v.p = p; v.n = n; v.w = w; v.pt = pt;
    tbl.push_back(v);
  endfunction

  // Rows after the edge that entered SERVE: SC-1 more SERVE rows, then PLAY.
  function automatic void serve_rows(input int s, input int x, input int y,
                                     input int p, input int n, input int w);
    for (int i = 0; i < SC - 1; i++) addv(s, x, y, 1, p, n, w, 0);
    addv(s, x, y, 2, p, n, w, 0);
  endfunction

  initial begin
    int s_r, x_r, y_r;
    model_reset();

    addv(0, 120, 100, 0, 0, 0, 0, 0);
    addv(1, 120, 100, 1, 0, 0, 0, 0);
    serve_rows(1, 120, 100, 0, 0, 0);
    addv(0, 120, 100, 2, 0, 0, 0, 0);
    addv(0, 120, 190, 1, 1, 0, 0, 1);
    serve_rows(0, 148, 100, 1, 0, 0);
    addv(0, 148, 100, 2, 1, 0, 0, 0);
    addv(0, 148, 195, 1, 1, 1, 1, 1);
    serve_rows(1, 120, 200, 1, 1, 1);
    addv(0, 120, 200, 2, 1, 1, 1, 0);
    addv(0, 120, 200, 2, 1, 1, 1, 0);
    addv(0, 120, 50,  2, 1, 1, 1, 0);
    addv(0, 120, 200, 1, 2, 1, 0, 1);
    serve_rows(0, 120, 200, 2, 1, 0);
    addv(0, 120, 200, 2, 2, 1, 0, 0);
    addv(0, 120, 200, 2, 2, 1, 0, 0);
    addv(0, 200, 50,  2, 2, 1, 0, 0);
    addv(0, 200, 200, 1, 2, 2, 1, 1);
    serve_rows(0, 120, 100, 2, 2, 1);
    addv(0, 120, 100, 2, 2, 2, 1, 0);
    addv(0, 120, 190, 1, 3, 2, 0, 1);
    serve_rows(0, 120, 100, 3, 2, 0);
    addv(0, 120, 100, 2, 3, 2, 0, 0);

    // Reset held for a few edges
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", int'(Game_state), 0);
    chk("reset point", int'(point), 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].x, tbl[i].y);
      chk($sformatf("row%0d state", i), int'(Game_state), tbl[i].st);
      chk($sformatf("row%0d player", i), int'(Player_score), tbl[i].p);
      chk($sformatf("row%0d npc", i), int'(NPC_score), tbl[i].n);
      chk($sformatf("row%0d who", i), int'(who_win), tbl[i].w);
      chk($sformatf("row%0d point", i), int'(point), tbl[i].pt);
    end

    // Mid-PLAY reset with scores 3/2
    async_reset("midplay");

    // Full game to WIN_SCORE, start held high through the final points
    step(0, 120, 100);
    step(1, 120, 100);
    chk("game start state", int'(Game_state), 1);
    repeat (SC) step(1, 120, 100);
    chk("game play state", int'(Game_state), 2);
    for (int k = 0; k < WS; k++) begin
      step(1, 120, 100);
      step(1, 120, 200);
      chk($sformatf("game pt%0d player", k), int'(Player_score), k + 1);
      chk($sformatf("game pt%0d pulse", k), int'(point), 1);
      if (k < WS - 1) repeat (SC) step(1, 120, 100);
    end
    chk("game over state", int'(Game_state), 3);
    repeat (3) step(1, 120, 100);
    chk("over held state", int'(Game_state), 3);
    chk("over held player", int'(Player_score), WS);
    chk("over held point", int'(point), 0);
    step(0, 120, 100);
    chk("over release state", int'(Game_state), 3);
    step(1, 120, 100);
    chk("restart state", int'(Game_state), 1);
    chk("restart player", int'(Player_score), 0);
    chk("restart npc", int'(NPC_score), 0);
    chk("restart who", int'(who_win), 0);

    // Randomized play
    async_reset("rand pre");
    s_r = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) s_r = 1 - s_r;
      if ($urandom_range(0, 7) == 0) x_r = 147 + $urandom_range(0, 1);
      else x_r = $urandom_range(0, 320);
      case ($urandom_range(0, 7))
        0:       y_r = 189 + $urandom_range(0, 1);
        1, 2, 3: y_r = $urandom_range(0, 180);
        7:       y_r = $urandom_range(3900, 4095);
        default: y_r = $urandom_range(190, 400);
      endcase
      step(s_r, x_r, y_r);
      if ($urandom_range(0, 599) == 0) async_reset("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
